i2c_target_regs: RTL and testbench

I2C_TARGET_REGS -- requirements
Module: i2c_target_regs

---
 rtl/i2c_target_regs.sv | 234 +++++++++++++++++++++++
 tb/tb_i2c_target_regs.sv | 220 ++++++++++++++++++++++
 2 files changed

// File: rtl/i2c_target_regs.sv
// I2C target exposing an 8 x 8-bit register file, with write-strobe notification.
// Bus lines are synchronized and glitch-filtered before any edge detection.
module i2c_target_regs #(
  parameter logic [6:0]  DEV_ADDR = 7'h7E,
  parameter int unsigned FILT_LEN = 3
) (
  input  logic       CLK40,
  input  logic       RST_N,
  input  logic       SCL_IN,
  input  logic       SDA_IN,
  output logic       SDA_OE,
  input  logic [2:0] RD_ADDR,
  output logic [7:0] RD_DATA,
  output logic       WR_STB,
  output logic [2:0] WR_ADDR,
  output logic [7:0] WR_DATA,
  output logic       BUSY,
  output logic       NACK_ERR
);

  typedef enum logic [3:0] {
    IDLE, ADDR, ADDR_ACK, PTR, PTR_ACK, WDATA, WDATA_ACK, RDATA, RDATA_ACK, IGNORE
  } state_t;

  logic [1:0]          r_scl_sync, r_sda_sync;
  logic [FILT_LEN-1:0] r_scl_hist, r_sda_hist;
  logic                r_scl_filt, r_sda_filt, r_scl_filt_d, r_sda_filt_d;

  state_t     r_state, w_state_nxt;
  logic [3:0] r_bitcnt, w_bitcnt_nxt;
  logic [7:0] r_shift, w_shift_nxt;
  logic [7:0] r_tx, w_tx_nxt;
  logic [2:0] r_ptr, w_ptr_nxt;
  logic       r_sda_oe, w_sda_oe_nxt;
  logic       r_busy, w_busy_nxt;
  logic       r_nack_err, w_nack_err_nxt;
  logic       r_rw, w_rw_nxt;
  logic       r_wr_stb, w_wr_stb_nxt;
  logic [2:0] r_wr_addr, w_wr_addr_nxt;
  logic [7:0] r_wr_data, w_wr_data_nxt;
  logic [7:0] r_regs [8];

  logic w_scl_rise, w_scl_fall, w_start, w_stop, w_sda_bit;

  // Two-flop synchronizers feeding a run-length filter; delayed copies for edges
  always_ff @(posedge CLK40) begin
    if (!RST_N) begin
      r_scl_sync   <= '1;
      r_sda_sync   <= '1;
      r_scl_hist   <= '1;
      r_sda_hist   <= '1;
      r_scl_filt   <= 1'b1;
      r_sda_filt   <= 1'b1;
      r_scl_filt_d <= 1'b1;
      r_sda_filt_d <= 1'b1;
    end else begin
      r_scl_sync   <= {r_scl_sync[0], SCL_IN};
      r_sda_sync   <= {r_sda_sync[0], SDA_IN};
      r_scl_hist   <= FILT_LEN'({r_scl_hist, r_scl_sync[1]});
      r_sda_hist   <= FILT_LEN'({r_sda_hist, r_sda_sync[1]});
      if (&r_scl_hist)       r_scl_filt <= 1'b1;
      else if (~|r_scl_hist) r_scl_filt <= 1'b0;
      if (&r_sda_hist)       r_sda_filt <= 1'b1;
      else if (~|r_sda_hist) r_sda_filt <= 1'b0;
      r_scl_filt_d <= r_scl_filt;
      r_sda_filt_d <= r_sda_filt;
    end
  end

  assign w_scl_rise = r_scl_filt & ~r_scl_filt_d;
  assign w_scl_fall = ~r_scl_filt & r_scl_filt_d;
  assign w_start    = r_scl_filt & r_scl_filt_d & r_sda_filt_d & ~r_sda_filt;
  assign w_stop     = r_scl_filt & r_scl_filt_d & ~r_sda_filt_d & r_sda_filt;
  assign w_sda_bit  = r_sda_filt;

  // Protocol FSM: next state and all registered outputs
  always_comb begin
    w_state_nxt    = r_state;
    w_bitcnt_nxt   = r_bitcnt;
    w_shift_nxt    = r_shift;
    w_tx_nxt       = r_tx;
    w_ptr_nxt      = r_ptr;
    w_sda_oe_nxt   = r_sda_oe;
    w_busy_nxt     = r_busy;
    w_nack_err_nxt = r_nack_err;
    w_rw_nxt       = r_rw;
    w_wr_stb_nxt   = 1'b0;
    w_wr_addr_nxt  = r_wr_addr;
    w_wr_data_nxt  = r_wr_data;
    if (w_stop) begin
      w_state_nxt  = IDLE;
      w_sda_oe_nxt = 1'b0;
      w_busy_nxt   = 1'b0;
    end else if (w_start) begin
      w_state_nxt  = ADDR;
      w_bitcnt_nxt = '0;
      w_sda_oe_nxt = 1'b0;
    end else begin
      case (r_state)
        ADDR, PTR, WDATA: begin
          if (w_scl_rise) begin
            w_shift_nxt  = {r_shift[6:0], w_sda_bit};
            w_bitcnt_nxt = r_bitcnt + 4'd1;
          end else if (w_scl_fall && r_bitcnt == 4'd8) begin
            w_bitcnt_nxt = '0;
            if (r_state == ADDR) begin
              if (r_shift[7:1] == DEV_ADDR) begin
                w_state_nxt    = ADDR_ACK;
                w_busy_nxt     = 1'b1;
                w_nack_err_nxt = 1'b0;
                w_rw_nxt       = r_shift[0];
                w_sda_oe_nxt   = 1'b1;
              end else begin
                w_state_nxt = IGNORE;
              end
            end else if (r_state == PTR) begin
              w_state_nxt  = PTR_ACK;
              w_ptr_nxt    = r_shift[2:0];
              w_sda_oe_nxt = 1'b1;
            end else begin
              w_state_nxt   = WDATA_ACK;
              w_wr_stb_nxt  = 1'b1;
              w_wr_addr_nxt = r_ptr;
              w_wr_data_nxt = r_shift;
              w_ptr_nxt     = r_ptr + 3'd1;
              w_sda_oe_nxt  = 1'b1;
            end
          end
        end
        ADDR_ACK: begin
          if (w_scl_fall) begin
            w_bitcnt_nxt = '0;
            if (r_rw) begin
              w_state_nxt  = RDATA;
              w_tx_nxt     = r_regs[r_ptr];
              w_sda_oe_nxt = ~r_regs[r_ptr][7];
            end else begin
              w_state_nxt  = PTR;
              w_sda_oe_nxt = 1'b0;
            end
          end
        end
        PTR_ACK, WDATA_ACK: begin
          if (w_scl_fall) begin
            w_state_nxt  = WDATA;
            w_bitcnt_nxt = '0;
            w_sda_oe_nxt = 1'b0;
          end
        end
        // A byte entered from ADDR_ACK is loaded on that exit fall; one entered
        // from a master ACK is loaded on the first fall seen with bitcnt==0.
        RDATA: begin
          if (w_scl_rise) begin
            w_bitcnt_nxt = r_bitcnt + 4'd1;
          end else if (w_scl_fall) begin
            if (r_bitcnt == 4'd8) begin
              w_state_nxt  = RDATA_ACK;
              w_bitcnt_nxt = '0;
              w_sda_oe_nxt = 1'b0;
            end else if (r_bitcnt == 4'd0) begin
              w_tx_nxt     = r_regs[r_ptr];
              w_sda_oe_nxt = ~r_regs[r_ptr][7];
            end else begin
              w_tx_nxt     = {r_tx[6:0], 1'b0};
              w_sda_oe_nxt = ~r_tx[6];
            end
          end
        end
        RDATA_ACK: begin
          if (w_scl_rise) begin
            w_bitcnt_nxt = '0;
            if (!w_sda_bit) begin
              w_ptr_nxt   = r_ptr + 3'd1;
              w_state_nxt = RDATA;
            end else begin
              w_nack_err_nxt = 1'b1;
              w_state_nxt    = IGNORE;
            end
          end
        end
        default: ;
      endcase
    end
  end

  // Protocol state register
  always_ff @(posedge CLK40) begin
    if (!RST_N) begin
      r_state    <= IDLE;
      r_bitcnt   <= '0;
      r_shift    <= '0;
      r_tx       <= '0;
      r_ptr      <= '0;
      r_sda_oe   <= 1'b0;
      r_busy     <= 1'b0;
      r_nack_err <= 1'b0;
      r_rw       <= 1'b0;
      r_wr_stb   <= 1'b0;
      r_wr_addr  <= '0;
      r_wr_data  <= '0;
    end else begin
      r_state    <= w_state_nxt;
      r_bitcnt   <= w_bitcnt_nxt;
      r_shift    <= w_shift_nxt;
      r_tx       <= w_tx_nxt;
      r_ptr      <= w_ptr_nxt;
      r_sda_oe   <= w_sda_oe_nxt;
      r_busy     <= w_busy_nxt;
      r_nack_err <= w_nack_err_nxt;
      r_rw       <= w_rw_nxt;
      r_wr_stb   <= w_wr_stb_nxt;
      r_wr_addr  <= w_wr_addr_nxt;
      r_wr_data  <= w_wr_data_nxt;
    end
  end

  // Register file commits at the end of the WR_STB cycle, so a same-cycle read sees the old value
  always_ff @(posedge CLK40) begin
    if (!RST_N) begin
      for (int unsigned i = 0; i < 8; i++) r_regs[i] <= '0;
    end else if (r_wr_stb) begin
      r_regs[r_wr_addr] <= r_wr_data;
    end
  end

  assign RD_DATA  = r_regs[RD_ADDR];
  assign SDA_OE   = r_sda_oe;
  assign BUSY     = r_busy;
  assign NACK_ERR = r_nack_err;
  assign WR_STB   = r_wr_stb;
  assign WR_ADDR  = r_wr_addr;
  assign WR_DATA  = r_wr_data;

endmodule

// File: tb/tb_i2c_target_regs.sv
// Directed bench for i2c_target_regs: a bit-banged master on an open-drain bus.
`timescale 1ns/1ps
module tb_i2c_target_regs;
  localparam int unsigned Q = 16;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       scl = 1'b1;
  logic       sda_m = 1'b1;
  logic [2:0] rd_addr = '0;
  logic       sda_oe, wr_stb, busy, nack_err;
  logic [2:0] wr_addr;
  logic [7:0] rd_data, wr_data;
  logic       sda_bus;

  assign sda_bus = sda_m & ~sda_oe;

  always #5 clk = ~clk;

  i2c_target_regs #(.DEV_ADDR(7'h7E), .FILT_LEN(3)) dut (
    .CLK40(clk), .RST_N(rst_n), .SCL_IN(scl), .SDA_IN(sda_bus), .SDA_OE(sda_oe),
    .RD_ADDR(rd_addr), .RD_DATA(rd_data), .WR_STB(wr_stb), .WR_ADDR(wr_addr),
    .WR_DATA(wr_data), .BUSY(busy), .NACK_ERR(nack_err)
  );

  int n_checks = 0;
  int n_fail   = 0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Bus monitor: strobe log, read-during-write snapshot, target drive count
  logic [10:0] stb_q[$];
  logic        prev_stb = 1'b0;
  logic [7:0]  rd_at_stb = '0, rd_next_stb = '0;
  int          oe_cnt = 0;
  always @(negedge clk) begin
    if (prev_stb) rd_next_stb = rd_data;
    if (wr_stb) begin
      stb_q.push_back({wr_addr, wr_data});
      rd_at_stb = rd_data;
    end
    prev_stb = wr_stb;
    if (sda_oe) oe_cnt++;
  end

  task automatic wq();
    repeat (Q) @(negedge clk);
  endtask

  task automatic i2c_start();
    sda_m = 1'b1; wq(); scl = 1'b1; wq(); sda_m = 1'b0; wq(); scl = 1'b0; wq();
  endtask

  task automatic i2c_stop();
    sda_m = 1'b0; wq(); scl = 1'b1; wq(); sda_m = 1'b1; wq();
  endtask

  task automatic put_bit(input logic b, input logic glitch, output logic seen);
    sda_m = b; wq(); scl = 1'b1; wq();
    seen = sda_bus;
    if (glitch) begin
      scl = 1'b0; @(negedge clk); scl = 1'b1;
      repeat (Q - 1) @(negedge clk);
    end else begin
      wq();
    end
    scl = 1'b0; wq();
  endtask

  task automatic send_byte(input logic [7:0] b, input int gbit, output logic ack);
    logic s;
    for (int unsigned i = 0; i < 8; i++) put_bit(b[7-i], (int'(7 - i) == gbit), s);
    put_bit(1'b1, 1'b0, ack);
  endtask

  task automatic recv_byte(input logic mack, output logic [7:0] d);
    logic s;
    for (int unsigned i = 0; i < 8; i++) begin
      put_bit(1'b1, 1'b0, s);
      d[7-i] = s;
    end
    put_bit(mack, 1'b0, s);
  endtask

  task automatic get_reg(input logic [2:0] a, output logic [7:0] d);
    rd_addr = a; #1; d = rd_data;
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "timeout");
  end

  initial begin
    logic       ack;
    logic [7:0] d;
    logic [7:0] rdv [3];
    int         nstb, ocnt;

    // Reset state
    repeat (5) @(negedge clk);
    chk("rst_oe", sda_oe, 0);
    chk("rst_busy", busy, 0);
    chk("rst_nack", nack_err, 0);
    chk("rst_stb", wr_stb, 0);
    chk("rst_waddr", wr_addr, 0);
    chk("rst_wdata", wr_data, 0);
    for (int unsigned i = 0; i < 8; i++) begin
      get_reg(3'(i), d);
      chk($sformatf("rst_reg%0d", i), d, 8'h00);
    end
    rst_n = 1'b1;
    wq();

    // Write FC,02,A5,5A
    i2c_start();
    send_byte(8'hFC, -1, ack); chk("w1_ack_addr", ack, 0);
    chk("w1_busy", busy, 1);
    send_byte(8'h02, -1, ack); chk("w1_ack_ptr", ack, 0);
    rd_addr = 3'd2;
    send_byte(8'hA5, -1, ack); chk("w1_ack_d0", ack, 0);
    chk("w1_rd_old", rd_at_stb, 8'h00);
    chk("w1_rd_new", rd_next_stb, 8'hA5);
    send_byte(8'h5A, -1, ack); chk("w1_ack_d1", ack, 0);
    chk("w1_busy_pre_stop", busy, 1);
    i2c_stop();
    chk("w1_busy_post_stop", busy, 0);
    chk("w1_nstb", stb_q.size(), 2);
    chk("w1_stb0", stb_q[0], {3'd2, 8'hA5});
    chk("w1_stb1", stb_q[1], {3'd3, 8'h5A});
    get_reg(3'd2, d); chk("w1_reg2", d, 8'hA5);
    get_reg(3'd3, d); chk("w1_reg3", d, 8'h5A);

    // Pointer wrap: FC,07,11,22
    i2c_start();
    send_byte(8'hFC, -1, ack); chk("w2_ack_addr", ack, 0);
    send_byte(8'h07, -1, ack); chk("w2_ack_ptr", ack, 0);
    send_byte(8'h11, -1, ack); chk("w2_ack_d0", ack, 0);
    send_byte(8'h22, -1, ack); chk("w2_ack_d1", ack, 0);
    i2c_stop();
    chk("w2_stb_last", stb_q[stb_q.size()-1], {3'd0, 8'h22});
    get_reg(3'd7, d); chk("w2_reg7", d, 8'h11);
    get_reg(3'd0, d); chk("w2_reg0", d, 8'h22);

    // Pointer set, repeated START, read 3 bytes ending in NACK
    i2c_start();
    send_byte(8'hFC, -1, ack); chk("r1_ack_addr", ack, 0);
    send_byte(8'h03, -1, ack); chk("r1_ack_ptr", ack, 0);
    i2c_start();
    send_byte(8'hFD, -1, ack); chk("r1_ack_rd", ack, 0);
    recv_byte(1'b0, rdv[0]);
    recv_byte(1'b0, rdv[1]);
    recv_byte(1'b1, rdv[2]);
    chk("r1_byte0", rdv[0], 8'h5A);
    chk("r1_byte1", rdv[1], 8'h00);
    chk("r1_byte2", rdv[2], 8'h00);
    chk("r1_oe_after_nack", sda_oe, 0);
    chk("r1_nack_err", nack_err, 1);
    i2c_stop();
    chk("r1_nack_sticky", nack_err, 1);
    chk("r1_busy", busy, 0);

    // Foreign address F8: never driven, nothing written
    nstb = stb_q.size();
    ocnt = oe_cnt;
    i2c_start();
    send_byte(8'hF8, -1, ack); chk("f_nack_addr", ack, 1);
    chk("f_busy", busy, 0);
    send_byte(8'h02, -1, ack); chk("f_nack_d0", ack, 1);
    send_byte(8'h77, -1, ack); chk("f_nack_d1", ack, 1);
    i2c_stop();
    chk("f_oe_cycles", oe_cnt - ocnt, 0);
    chk("f_nstb", stb_q.size(), nstb);
    get_reg(3'd2, d); chk("f_reg2", d, 8'hA5);

    // SCL glitch inside a data bit
    i2c_start();
    send_byte(8'hFC, -1, ack); chk("g_ack_addr", ack, 0);
    chk("g_nack_cleared", nack_err, 0);
    send_byte(8'h05, -1, ack); chk("g_ack_ptr", ack, 0);
    send_byte(8'hC3, 4, ack); chk("g_ack_d0", ack, 0);
    i2c_stop();
    chk("g_stb", stb_q[stb_q.size()-1], {3'd5, 8'hC3});
    get_reg(3'd5, d); chk("g_reg5", d, 8'hC3);

    // Reset while driving the first read bit of regs[0]=22
    i2c_start();
    send_byte(8'hFC, -1, ack); chk("x_ack_addr", ack, 0);
    send_byte(8'h00, -1, ack); chk("x_ack_ptr", ack, 0);
    i2c_start();
    send_byte(8'hFD, -1, ack); chk("x_ack_rd", ack, 0);
    chk("x_oe_driving", sda_oe, 1);
    rst_n = 1'b0;
    @(posedge clk); #1;
    chk("x_oe_released", sda_oe, 0);
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    wq();
    chk("x_busy_after_rst", busy, 0);
    i2c_start();
    send_byte(8'hFC, -1, ack); chk("x2_ack_addr", ack, 0);
    send_byte(8'h01, -1, ack); chk("x2_ack_ptr", ack, 0);
    send_byte(8'h33, -1, ack); chk("x2_ack_d0", ack, 0);
    i2c_stop();
    chk("x2_stb", stb_q[stb_q.size()-1], {3'd1, 8'h33});
    get_reg(3'd1, d); chk("x2_reg1", d, 8'h33);
    get_reg(3'd0, d); chk("x2_reg0_cleared", d, 8'h00);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
